// File: rtl/vga_axil_regbank.sv
// vga_axil_regbank: AXI4-Lite slave exposing four 32-bit control registers to the VGA core.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN   clock (rising edge) and async active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, write data, write response channels
//   S_AXI_AR* / S_AXI_R*         read address and read data channels
//   reg0_o..reg3_o               current register contents
//   reg_wr_o                     one-hot single-cycle pulse for the register just written
//
// Build option: define VGA_AXIL_REGBANK_WSTRB_EN to honour WSTRB byte lanes;
// otherwise every write replaces all 32 bits.
module vga_axil_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
    output logic [3:0]                      reg_wr_o
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t       w_state, w_next;
    r_state_t       r_state, r_next;
    logic           rdy_en;
    logic [DW-1:0]  regs [4];
    logic [1:0]     aw_idx_q;
    logic [DW-1:0]  wdata_q;
    logic [SW-1:0]  wstrb_q;
    logic           aw_hs, w_hs, ar_hs, commit;
    logic [1:0]     wr_idx;
    logic [DW-1:0]  wr_data, wr_val;
    logic [SW-1:0]  wr_strb;
    logic           unused_ok;

    // Ready lines stay low while in reset and for the edge that releases it.
    assign S_AXI_AWREADY = rdy_en && (w_state == W_IDLE || w_state == W_DATA);
    assign S_AXI_WREADY  = rdy_en && (w_state == W_IDLE || w_state == W_ADDR);
    assign S_AXI_ARREADY = rdy_en && r_state == R_IDLE;
    assign S_AXI_BVALID  = w_state == W_RESP;
    assign S_AXI_RVALID  = r_state == R_DATA;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Whichever half of the write arrives last is taken straight from the bus.
    assign wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, wr_strb};

    always_comb begin
        wr_val = wr_data;
`ifdef VGA_AXIL_REGBANK_WSTRB_EN
        for (int n = 0; n < SW; n++)
            wr_val[8*n +: 8] = wr_strb[n] ? wr_data[8*n +: 8] : regs[wr_idx][8*n +: 8];
`endif
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_ADDR : w_hs ? W_DATA : W_IDLE;
            W_ADDR:  w_next = w_hs ? W_RESP : W_ADDR;
            W_DATA:  w_next = aw_hs ? W_RESP : W_DATA;
            W_RESP:  w_next = S_AXI_BREADY ? W_IDLE : W_RESP;
            default: w_next = W_IDLE;
        endcase
        commit = w_next == W_RESP && w_state != W_RESP;
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (S_AXI_RREADY ? R_IDLE : R_DATA);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            rdy_en      <= 1'b0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            reg_wr_o    <= '0;
            S_AXI_RDATA <= '0;
            for (int i = 0; i < 4; i++)
                regs[i] <= '0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            rdy_en   <= 1'b1;
            reg_wr_o <= commit ? 4'(1) << wr_idx : 4'b0000;
            if (aw_hs)
                aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            // Nonblocking read of regs gives a same-edge read the pre-write value.
            if (ar_hs)
                S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
            for (int i = 0; i < 4; i++)
                if (commit && wr_idx == 2'(i))
                    regs[i] <= wr_val;
        end
    end

    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];
endmodule

// File: doc/vga_axil_regbank.md
VGA_AXIL_REGBANK -- requirements
Module: vga_axil_regbank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; bits [3:2] select one of four registers, bits [1:0] ignored.
REQ-003 SHALL have port S_AXI_ACLK  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports S_AXI_AWADDR in 4, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write-address channel.
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write-data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write-response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in 4, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read-address channel.
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read-data channel.
REQ-010 SHALL have ports reg0_o..reg3_o  output  32 each  current register contents, to VGA core.
REQ-011 SHALL have port reg_wr_o  output  4  one-hot, one-cycle pulse marking the register written.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_ADDR (AW accepted, awaiting W), W_DATA (W accepted, awaiting AW), W_RESP.
REQ-013 In W_IDLE: AWREADY=WREADY=1; AW+W same cycle -> W_RESP; AW only -> W_ADDR; W only -> W_DATA.
REQ-014 In W_ADDR only WREADY=1; in W_DATA only AWREADY=1; completing handshake -> W_RESP.
REQ-015 Register update and reg_wr_o pulse SHALL occur on the edge completing the second of AW/W; BVALID rises that same edge.
REQ-016 In W_RESP: BVALID=1, BRESP=2'b00; hold until BREADY; BVALID&BREADY -> W_IDLE, no new AW/W accepted in W_RESP.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-018 AR handshake SHALL capture RDATA from selected register on that edge -> R_DATA; RRESP=2'b00; RDATA/RVALID stable until RREADY; RVALID&RREADY -> R_IDLE.
REQ-019 Read latency SHALL be 1 cycle (RVALID the cycle after AR handshake); write latency 1 cycle after second of AW/W.
REQ-020 Read and write FSMs SHALL run independently; read capturing the same edge a write commits SHALL return the pre-write value.
REQ-021 All addresses in range; no SLVERR/DECERR ever generated.
REQ-022 reg_wr_o SHALL be 4'b0000 in all cycles without a commit.

Reset
REQ-023 On S_AXI_ARESETN low, asynchronously: both FSMs to IDLE, reg0_o..reg3_o=0, reg_wr_o=0, BVALID=RVALID=0, RDATA=0, BRESP=RRESP=0.
REQ-024 AWREADY, WREADY, ARREADY SHALL be 0 while reset asserted and rise the first cycle after deassertion.
REQ-025 Reset mid-transaction SHALL abandon it with no register update; partial AW/W state discarded.

Configuration
REQ-026 Macro VGA_AXIL_REGBANK_WSTRB_EN: defined -> byte lane n written only when WSTRB[n]=1; WSTRB=0 still completes with OKAY and pulses reg_wr_o.
REQ-027 Undefined -> WSTRB ignored, every write updates all 32 bits.

Verification
REQ-028 Reset release -> reads of 0x0,0x4,0x8,0xC return 0x00000000, RRESP=OKAY.
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, WSTRB=4'hF -> read back 0x1..0x4; reg3_o=0x4; reg_wr_o pulses 0001,0010,0100,1000.
REQ-030 W (0xDEADBEEF) two cycles before AW (0x8), BREADY low 3 cycles -> reg2_o updates once, BVALID held 3 cycles, no further AWREADY/WREADY until B handshake.
REQ-031 reg1=0x00000001, write 0xAABBCCDD WSTRB=4'b0010 -> reg1_o=0x0000CC01 with macro, 0xAABBCCDD without.
REQ-032 Read of 0x0 issued the cycle write to 0x0 (0x55) commits, old value 0x1 -> RDATA=0x1; next read -> 0x55.
REQ-033 AW accepted, ARESETN pulsed low before W -> no register change, all outputs zero, next full write completes normally.
